// File: rtl/seg7_scan_dec.sv
// Multiplexed 7-segment scanner: synchronises strobe/segment pins,
// waits for a stable window, then decodes the strobed digit.
module seg7_scan_dec #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  com,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   dig_val,
    output logic [DIGITS-1:0]     dig_blank,
    output logic [DIGITS-1:0]     dig_err,
    output logic                  upd,
    output logic                  frame_done
);
    localparam int         W   = DIGITS + 8;
    localparam logic [7:0] LIM = 8'(STABLE_CYC);

    logic [W-1:0]      s1, s2, prev, cap;
    logic [7:0]        cnt;
    logic              diff, fire, fire_q;
    logic [DIGITS-1:0] sel, seen, seen_nx;
    logic [6:0]        n;
    logic [3:0]        val;
    logic              hit, blank, onehot;

    assign diff = (s2 != prev);
    assign fire = !diff && (cnt == LIM - 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            prev   <= '0;
            cnt    <= '0;
            fire_q <= 1'b0;
            cap    <= '0;
        end else begin
            s1     <= {com, dig_sel, seg_in};
            s2     <= s1;
            prev   <= s2;
            fire_q <= fire;
            if (fire)
                cap <= s2;
            if (diff)
                cnt <= '0;
            else if (cnt != LIM)
                cnt <= cnt + 8'd1;
        end
    end

    // Captured sample is decoded one cycle after the window closes
    assign sel     = cap[W-2:7];
    assign onehot  = $onehot(sel);
    assign seen_nx = seen | sel;
    assign n       = cap[W-1] ? cap[6:0] : ~cap[6:0];
    assign blank   = (n == 7'b1111111);

    always_comb begin
        hit = 1'b1;
        val = 4'h0;
        unique case (n)
            7'b1000000: val = 4'h0;
            7'b1111001: val = 4'h1;
            7'b0100100: val = 4'h2;
            7'b0110000: val = 4'h3;
            7'b0011001: val = 4'h4;
            7'b0010010: val = 4'h5;
            7'b0000010: val = 4'h6;
            7'b1111000: val = 4'h7;
            7'b0000000: val = 4'h8;
            7'b0010000: val = 4'h9;
            7'b0001000: val = 4'hA;
            7'b0000011: val = 4'hB;
            7'b1000110: val = 4'hC;
            7'b0100001: val = 4'hD;
            7'b0000110: val = 4'hE;
            7'b0001110: val = 4'hF;
            default:    hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dig_val    <= '0;
            dig_blank  <= '1;
            dig_err    <= '0;
            upd        <= 1'b0;
            frame_done <= 1'b0;
            seen       <= '0;
        end else begin
            upd        <= 1'b0;
            frame_done <= 1'b0;
            if (fire_q && onehot) begin
                upd <= 1'b1;
                for (int i = 0; i < DIGITS; i++) begin
                    if (sel[i]) begin
                        if (blank) begin
                            dig_val[4*i +: 4] <= 4'h0;
                            dig_blank[i]      <= 1'b1;
                            dig_err[i]        <= 1'b0;
                        end else if (hit) begin
                            dig_val[4*i +: 4] <= val;
                            dig_blank[i]      <= 1'b0;
                            dig_err[i]        <= 1'b0;
                        end else begin
                            dig_blank[i] <= 1'b0;
                            dig_err[i]   <= 1'b1;
                        end
                    end
                end
                if (&seen_nx) begin
                    frame_done <= 1'b1;
                    seen       <= '0;
                end else begin
                    seen <= seen_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_dec.sv
// Bench for seg7_scan_dec: directed scenarios plus random strobing,
// checked every cycle against a window/latency reference model.
module tb_seg7_scan_dec;
    localparam int DIGITS     = 4;
    localparam int STABLE_CYC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        com = 1'b0;
    logic [6:0]  seg_in = 7'h00;
    logic [3:0]  dig_sel = 4'h0;
    logic [15:0] dig_val;
    logic [3:0]  dig_blank, dig_err;
    logic        upd, frame_done;

    seg7_scan_dec #(.DIGITS(DIGITS), .STABLE_CYC(STABLE_CYC)) dut (
        .clk(clk), .rst(rst), .com(com), .seg_in(seg_in),
        .dig_sel(dig_sel), .dig_val(dig_val), .dig_blank(dig_blank),
        .dig_err(dig_err), .upd(upd), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic       c;
        logic [3:0] s;
        logic [6:0] g;
    } cap_t;

    logic [6:0] pat [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    cap_t        q[$];
    int          checks = 0, errors = 0, cyc = 0;
    int          run_len = 0, upd_n = 0, fd_n = 0;
    bit          run_ok = 0;
    logic [11:0] run_v;
    logic [15:0] mval = '0;
    logic [3:0]  mblank = '1, merr = '0, mseen = '0;
    logic        eupd, efd;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h cycle %0d",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic apply_cap(input cap_t c);
        logic [6:0] n;
        int v;
        n = c.c ? c.g : ~c.g;
        v = -1;
        for (int i = 0; i < 16; i++)
            if (pat[i] == n) v = i;
        for (int i = 0; i < DIGITS; i++) begin
            if (c.s[i]) begin
                if (n == 7'h7f) begin
                    mval[4*i +: 4] = 4'h0; mblank[i] = 1'b1; merr[i] = 1'b0;
                end else if (v >= 0) begin
                    mval[4*i +: 4] = 4'(v); mblank[i] = 1'b0; merr[i] = 1'b0;
                end else begin
                    mblank[i] = 1'b0; merr[i] = 1'b1;
                end
            end
        end
        eupd = 1'b1;
        mseen = mseen | c.s;
        if (mseen == 4'hF) begin
            efd = 1'b1;
            mseen = 4'h0;
        end
    endtask

    // A pin value held for STABLE_CYC+1 edges shows up STABLE_CYC+3
    // edges after the first edge that sampled it.
    task automatic tick();
        logic [11:0] cur;
        cap_t        e;
        @(posedge clk);
        cyc++;
        cur  = {com, dig_sel, seg_in};
        eupd = 1'b0;
        efd  = 1'b0;
        if (rst) begin
            mval = '0; mblank = '1; merr = '0; mseen = '0;
            q.delete();
            run_ok = 0;
        end else begin
            if (!run_ok || cur != run_v) begin
                run_v = cur; run_len = 1; run_ok = 1;
            end else begin
                run_len++;
            end
            if (run_len == STABLE_CYC + 1 && $onehot(cur[10:7])) begin
                e.at = cyc + 3; e.c = cur[11]; e.s = cur[10:7]; e.g = cur[6:0];
                q.push_back(e);
            end
            if (q.size() > 0 && q[0].at == cyc) begin
                apply_cap(q[0]);
                void'(q.pop_front());
            end
        end
        #1;
        if (upd === 1'b1) upd_n++;
        if (frame_done === 1'b1) fd_n++;
        chk("upd", 16'(upd), 16'(eupd));
        chk("frame_done", 16'(frame_done), 16'(efd));
        chk("dig_val", dig_val, mval);
        chk("dig_blank", 16'(dig_blank), 16'(mblank));
        chk("dig_err", 16'(dig_err), 16'(merr));
    endtask

    task automatic step(input logic c, input logic [3:0] s,
                        input logic [6:0] g, input int n);
        com = c; dig_sel = s; seg_in = g;
        repeat (n) tick();
    endtask

    task automatic rst_pulse(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    initial begin
        logic       c;
        logic [3:0] s;
        logic [6:0] nn, g;
        int         h, kind;

        tick();
        tick();
        chk("rst_blank", 16'(dig_blank), 16'hF);
        chk("rst_val", dig_val, 16'h0);
        rst = 1'b0;

        upd_n = 0;
        step(1'b1, 4'b0001, 7'b0100100, 12);
        chk("r030_updn", 16'(upd_n), 16'd1);
        chk("r030_val", 16'(dig_val[3:0]), 16'h2);

        step(1'b0, 4'b0100, 7'b1101101, 10);
        chk("r031_5", 16'(dig_val[11:8]), 16'h5);
        step(1'b0, 4'b0100, 7'b1111100, 10);
        chk("r031_b", 16'(dig_val[11:8]), 16'hB);
        step(1'b0, 4'b0100, 7'b1111101, 10);
        chk("r031_6", 16'(dig_val[11:8]), 16'h6);

        step(1'b1, 4'b0010, 7'b0110000, 10);
        upd_n = 0;
        step(1'b1, 4'b0010, 7'b0000000, 2);
        step(1'b1, 4'b0010, 7'b0110000, 10);
        chk("r032_updn", 16'(upd_n), 16'd1);
        chk("r032_val", 16'(dig_val[7:4]), 16'h3);

        step(1'b1, 4'b1000, 7'b0010000, 10);
        step(1'b1, 4'b1000, 7'b1010101, 10);
        chk("r034_err", 16'(dig_err[3]), 16'd1);
        chk("r034_val", 16'(dig_val[15:12]), 16'h9);
        upd_n = 0;
        step(1'b1, 4'b0011, 7'b0110000, 10);
        step(1'b1, 4'b0000, 7'b0110000, 10);
        chk("r034_noupd", 16'(upd_n), 16'd0);
        step(1'b1, 4'b1000, 7'b1111111, 10);
        chk("r034_blank", 16'(dig_blank[3]), 16'd1);
        chk("r034_zero", 16'(dig_val[15:12]), 16'h0);

        upd_n = 0;
        step(1'b1, 4'b0001, 7'b0011001, 2);
        rst_pulse(1);
        chk("r035_blank", 16'(dig_blank), 16'hF);
        step(1'b1, 4'b0001, 7'b0011001, 12);
        chk("r035_updn", 16'(upd_n), 16'd1);
        chk("r035_val", 16'(dig_val[3:0]), 16'h4);

        rst_pulse(2);
        upd_n = 0;
        fd_n  = 0;
        step(1'b1, 4'b0001, 7'b1111001, 8);
        step(1'b1, 4'b0001, 7'b1111000, 8);
        step(1'b1, 4'b0010, 7'b0001000, 8);
        step(1'b1, 4'b0100, 7'b1000110, 8);
        step(1'b1, 4'b1000, 7'b0100001, 8);
        step(1'b1, 4'b1000, 7'b0100001, 4);
        chk("r033_updn", 16'(upd_n), 16'd5);
        chk("r033_fd", 16'(fd_n), 16'd1);
        step(1'b0, 4'b0001, 7'b1111111, 8);
        step(1'b0, 4'b0010, 7'b1111111, 8);
        step(1'b0, 4'b0100, 7'b1111111, 10);
        chk("r033_fd_part", 16'(fd_n), 16'd1);
        step(1'b0, 4'b1000, 7'b1111111, 10);
        chk("r033_fd_next", 16'(fd_n), 16'd2);

        for (int k = 0; k < 80; k++) begin
            if (k == 40) rst_pulse(1);
            c = 1'($urandom);
            if ($urandom_range(0, 9) == 0)
                s = 4'($urandom);
            else
                s = 4'(1 << $urandom_range(0, 3));
            kind = $urandom_range(0, 5);
            if (kind <= 3)
                nn = pat[$urandom_range(0, 15)];
            else if (kind == 4)
                nn = 7'h7f;
            else
                nn = 7'($urandom);
            g = c ? nn : ~nn;
            if ($urandom_range(0, 3) == 0)
                h = $urandom_range(1, 2);
            else
                h = $urandom_range(8, 12);
            step(c, s, g, h);
        end
        step(1'b1, 4'b0000, 7'b0000000, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
